// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin sharing of one iterative divider among N_REQ
// requesters. Each request runs as an atomic job. A zero divisor is answered
// locally without using the divider, and a hung divider is cut off by a timeout.
module div_share_arbiter #(
  parameter int N_REQ    = 2,
  parameter int WIDTH    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] dividend_i,
  input  logic [N_REQ*WIDTH-1:0] divisor_i,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [1:0]             rsp_err,
  output logic [WIDTH-1:0]       quotient_o,
  output logic [WIDTH-1:0]       remainder_o,
  output logic                   busy,
  output logic                   div_load,
  output logic [WIDTH-1:0]       div_a,
  output logic [WIDTH-1:0]       div_b,
  input  logic [WIDTH-1:0]       div_quot,
  input  logic [WIDTH-1:0]       div_rem,
  input  logic                   div_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    win_q, win_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [1:0]       err_q, err_d;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;

  logic [IW-1:0]    win_sel;
  logic [WIDTH-1:0] sel_a, sel_b;

  // Round-robin pick: first set request bit at or above rr_ptr, wrapping.
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    win_sel = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_sel = IW'(idx);
      end
    end
    sel_a = dividend_i[win_sel*WIDTH +: WIDTH];
    sel_b = divisor_i[win_sel*WIDTH +: WIDTH];
  end

  // Next-state and datapath latching for the job sequence.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    win_d      = win_q;
    a_d        = a_q;
    b_d        = b_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          win_d = win_sel;
          a_d   = sel_a;
          b_d   = sel_b;
          if (sel_b == '0) begin
            // Answered locally; the divider is never started.
            err_d   = ERR_DIV0;
            quot_d  = '1;
            rem_d   = sel_a;
            state_d = RESP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // done is checked first so a coincident done beats the timeout.
        if (div_done) begin
          err_d   = ERR_OK;
          quot_d  = div_quot;
          rem_d   = div_rem;
          state_d = RESP;
        end else if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
          err_d   = ERR_TMO;
          quot_d  = '0;
          rem_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (int'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any job in flight without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      win_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      err_q      <= ERR_OK;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      win_q      <= win_d;
      a_q        <= a_d;
      b_q        <= b_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Strobes decoded from state; grant also fires in RESP for the zero-divisor job.
  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    if (state_q == LOAD || (state_q == RESP && err_q == ERR_DIV0))
      gnt = N_REQ'(1) << win_q;
    if (state_q == RESP)
      rsp_valid = N_REQ'(1) << win_q;
  end

  assign busy        = (state_q != IDLE);
  assign div_load    = (state_q == LOAD);
  assign div_a       = a_q;
  assign div_b       = b_q;
  assign rsp_err     = err_q;
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a behavioural divider whose
// done latency is programmable per step (0 = never completes).
module tb_div_share_arbiter;

  localparam int N = 2;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] dividend_i, divisor_i;
  logic [N-1:0]   gnt, rsp_valid;
  logic [1:0]     rsp_err;
  logic [W-1:0]   quotient_o, remainder_o;
  logic           busy, div_load;
  logic [W-1:0]   div_a, div_b, div_quot, div_rem;
  logic           div_done;

  int checks = 0;
  int errors = 0;

  int dly  = 0;
  int left = 0;

  div_share_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_WAIT(64)) dut (
    .clk(clk), .rst(rst), .req(req),
    .dividend_i(dividend_i), .divisor_i(divisor_i),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .quotient_o(quotient_o), .remainder_o(remainder_o),
    .busy(busy), .div_load(div_load), .div_a(div_a), .div_b(div_b),
    .div_quot(div_quot), .div_rem(div_rem), .div_done(div_done)
  );

  always #5 clk = ~clk;

  // Divider model: done is high in the cycle that is dly cycles after the load cycle.
  always @(posedge clk) begin
    if (div_load) left <= dly;
    else if (left > 0) left <= left - 1;
  end
  assign div_done = (left == 1);
  assign div_quot = (div_b != 0) ? div_a / div_b : '0;
  assign div_rem  = (div_b != 0) ? div_a % div_b : '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    dividend_i[idx*W +: W] = a;
    divisor_i[idx*W +: W]  = b;
  endtask

  logic [1:0] g_exp [1:11] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00,
                               2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
  logic [1:0] v_exp [1:11] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00,
                               2'b10, 2'b00, 2'b00, 2'b00, 2'b01};

  initial begin
    rst = 1'b1; req = '0; dividend_i = '0; divisor_i = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_load", div_load, 0);
    chk("rst_q", quotient_o, 0);
    chk("rst_r", remainder_o, 0);
    chk("rst_err", rsp_err, 0);
    rst = 1'b0;

    // 1: single request 100/7, done 5 cycles after load
    dly = 5; set_ops(0, 16'd100, 16'd7); req = 2'b01;
    tick();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_load", div_load, 1);
    chk("t1_a", div_a, 100);
    chk("t1_b", div_b, 7);
    req = 2'b00;
    tick();
    chk("t1_gnt_off", gnt, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("t1_rsp_early", rsp_valid, 0);
    tick();
    chk("t1_rsp", rsp_valid, 2'b01);
    chk("t1_q", quotient_o, 14);
    chk("t1_r", remainder_o, 2);
    chk("t1_err", rsp_err, 0);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_q_held", quotient_o, 14);

    // 2: both requesting continuously from a fresh pointer -> 0,1,0
    rst = 1'b1; tick(); rst = 1'b0;
    dly = 1; set_ops(0, 16'd50, 16'd5); set_ops(1, 16'd9, 16'd4); req = 2'b11;
    for (int c = 1; c <= 11; c++) begin
      tick();
      chk($sformatf("t2_gnt_c%0d", c), gnt, g_exp[c]);
      chk($sformatf("t2_rsp_c%0d", c), rsp_valid, v_exp[c]);
      if (c == 7) begin
        chk("t2_q1", quotient_o, 2);
        chk("t2_r1", remainder_o, 1);
      end
    end
    req = 2'b00;
    chk("t2_q0", quotient_o, 10);
    tick();
    chk("t2_idle", busy, 0);

    // 3: zero divisor on requester 1
    set_ops(1, 16'h1234, 16'h0000); req = 2'b10;
    tick();
    chk("t3_gnt", gnt, 2'b10);
    chk("t3_rsp", rsp_valid, 2'b10);
    chk("t3_q", quotient_o, 16'hFFFF);
    chk("t3_r", remainder_o, 16'h1234);
    chk("t3_err", rsp_err, 2'b01);
    chk("t3_load", div_load, 0);
    req = 2'b00;
    tick();
    chk("t3_idle", busy, 0);
    chk("t3_load2", div_load, 0);

    // 4: divider hangs -> timeout 64 cycles after WAIT entry
    dly = 0; set_ops(0, 16'd10, 16'd3); req = 2'b01;
    tick();
    chk("t4_gnt", gnt, 2'b01);
    req = 2'b00;
    for (int i = 0; i < 64; i++) tick();
    chk("t4_rsp_early", rsp_valid, 0);
    chk("t4_busy", busy, 1);
    tick();
    chk("t4_rsp", rsp_valid, 2'b01);
    chk("t4_err", rsp_err, 2'b10);
    chk("t4_q", quotient_o, 0);
    chk("t4_r", remainder_o, 0);
    tick();
    chk("t4_idle", busy, 0);
    // pointer now at 1, so a two-way request goes to requester 1
    dly = 2; set_ops(1, 16'd20, 16'd4); req = 2'b11;
    tick();
    chk("t4b_gnt", gnt, 2'b10);
    req = 2'b00;
    tick(); tick();
    tick();
    chk("t4b_rsp", rsp_valid, 2'b10);
    chk("t4b_q", quotient_o, 5);
    chk("t4b_err", rsp_err, 0);
    tick();

    // 6: done coincides with the final timeout cycle -> done wins
    dly = 64; set_ops(0, 16'd1000, 16'd9); req = 2'b01;
    tick();
    chk("t6_gnt", gnt, 2'b01);
    req = 2'b00;
    for (int i = 0; i < 64; i++) tick();
    chk("t6_rsp_early", rsp_valid, 0);
    tick();
    chk("t6_rsp", rsp_valid, 2'b01);
    chk("t6_err", rsp_err, 0);
    chk("t6_q", quotient_o, 111);
    chk("t6_r", remainder_o, 1);
    tick();

    // 5: reset during WAIT aborts silently and restores the pointer
    dly = 0; set_ops(0, 16'd8, 16'd2); req = 2'b01;
    tick();
    chk("t5_gnt", gnt, 2'b01);
    req = 2'b00;
    tick(); tick();
    chk("t5_in_wait", busy, 1);
    rst = 1'b1;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_rsp", rsp_valid, 0);
    rst = 1'b0;
    tick();
    chk("t5_rsp2", rsp_valid, 0);
    dly = 1; set_ops(0, 16'd8, 16'd2); set_ops(1, 16'd30, 16'd6); req = 2'b11;
    tick();
    chk("t5_gnt_post", gnt, 2'b01);
    req = 2'b00;
    tick();
    tick();
    chk("t5_rsp_post", rsp_valid, 2'b01);
    chk("t5_q_post", quotient_o, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
